// File: rtl/qsys_sdram_cpu_ocimem_pkg.sv
// ============================================================================
// Module   : qsys_sdram_cpu_ocimem_pkg
// Brief    : Shared defaults, jdo field positions and CPU FSM state encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package qsys_sdram_cpu_ocimem_pkg;

    localparam int c_RAM_DEPTH     = 256;
    localparam int c_ADDR_W        = 8;

    localparam int c_JDO_ADDR_MSB  = 33;
    localparam int c_JDO_ADDR_LSB  = 26;
    localparam int c_JDO_RD_BIT    = 34;
    localparam int c_JDO_DATA_MSB  = 34;
    localparam int c_JDO_DATA_LSB  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD1  = 2'd1,
        ST_RD2  = 2'd2,
        ST_DONE = 2'd3
    } cpu_state_e;

endpackage

`default_nettype wire

// File: rtl/qsys_sdram_cpu_ociram_sp_ram.sv
// ============================================================================
// Module   : qsys_sdram_cpu_ociram_sp_ram
// Brief    : Single-port byte-enabled RAM with one-cycle registered read
// Revision : 1.0
// ============================================================================
`default_nettype none

module qsys_sdram_cpu_ociram_sp_ram
    import qsys_sdram_cpu_ocimem_pkg::*;
#(
    parameter int RAM_DEPTH = c_RAM_DEPTH,
    parameter int ADDR_W    = c_ADDR_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       q_o
);

    logic [31:0] mem [RAM_DEPTH];
    logic [31:0] q_q;

    // Output register only moves on a read so a captured word survives idle cycles.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            q_q <= mem[addr_i];
        end
    end

    assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/qsys_sdram_cpu_ocimem.sv
// ============================================================================
// Module   : qsys_sdram_cpu_ocimem
// Brief    : Debug on-chip memory shared between JTAG monitor and CPU Avalon port
// Revision : 1.0
// ============================================================================
`default_nettype none

module qsys_sdram_cpu_ocimem
    import qsys_sdram_cpu_ocimem_pkg::*;
#(
    parameter int RAM_DEPTH = c_RAM_DEPTH,
    parameter int ADDR_W    = c_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [3:0]        byteenable,
    input  logic [31:0]       writedata,
    input  logic              debugaccess,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg
);

    logic              rd_pend_q;
    logic              wr_pend_q;
    logic              rd_inflight_q;
    logic [31:0]       mon_dreg_q;
    logic [ADDR_W-1:0] mon_areg_q;

    cpu_state_e        state_q;
    logic              waitrequest_q;
    logic [31:0]       readdata_q;
    logic [31:0]       rd_hold_q;

    logic              w_strobe;
    logic              w_new_rd;
    logic              w_new_wr;
    logic              w_req_rd;
    logic              w_req_wr;
    logic              w_jtag_grant;
    logic              w_cpu_grant;
    logic [ADDR_W-1:0] w_jtag_addr;
    logic [31:0]       w_jtag_wdata;
    logic [ADDR_W-1:0] w_addr_inc;

    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [3:0]        w_ram_be;
    logic [31:0]       w_ram_wdata;
    logic [31:0]       w_ram_q;

    logic              w_unused_jdo;
    assign w_unused_jdo = ^{jdo[37:35], jdo[2:0]};

    // A strobe is a request in its own cycle and supersedes any ungranted pending access;
    // only an in-flight JTAG read holds JTAG off, so its address increment lands first.
    always_comb begin
        w_strobe     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
        w_new_rd     = (take_action_ocimem_a & jdo[c_JDO_RD_BIT]) |
                       (~take_action_ocimem_a & take_no_action_ocimem_a);
        w_new_wr     = ~take_action_ocimem_a & ~take_no_action_ocimem_a & take_action_ocimem_b;
        w_req_rd     = w_strobe ? w_new_rd : rd_pend_q;
        w_req_wr     = w_strobe ? w_new_wr : wr_pend_q;
        w_jtag_grant = (w_req_rd | w_req_wr) & ~rd_inflight_q;
        w_jtag_addr  = take_action_ocimem_a ? jdo[c_JDO_ADDR_LSB +: ADDR_W] : mon_areg_q;
        w_jtag_wdata = w_new_wr ? jdo[c_JDO_DATA_MSB:c_JDO_DATA_LSB] : mon_dreg_q;
        w_cpu_grant  = (state_q == ST_IDLE) & chipselect & (read | write) & ~(w_req_rd | w_req_wr);
        w_addr_inc   = (mon_areg_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : mon_areg_q + ADDR_W'(1);

        w_ram_addr   = address;
        w_ram_we     = 1'b0;
        w_ram_re     = 1'b0;
        w_ram_be     = 4'hF;
        w_ram_wdata  = writedata;
        if (w_jtag_grant) begin
            w_ram_addr  = w_jtag_addr;
            w_ram_we    = w_req_wr;
            w_ram_re    = w_req_rd;
            w_ram_wdata = w_jtag_wdata;
        end else if (w_cpu_grant) begin
            w_ram_we    = write & ~read & debugaccess;
            w_ram_re    = read;
            w_ram_be    = byteenable;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q     <= 1'b0;
            wr_pend_q     <= 1'b0;
            rd_inflight_q <= 1'b0;
            mon_dreg_q    <= '0;
            mon_areg_q    <= '0;
        end else begin
            rd_pend_q     <= w_req_rd & ~w_jtag_grant;
            wr_pend_q     <= w_req_wr & ~w_jtag_grant;
            rd_inflight_q <= w_jtag_grant & w_req_rd;
            if (w_new_wr) begin
                mon_dreg_q <= jdo[c_JDO_DATA_MSB:c_JDO_DATA_LSB];
            end else if (rd_inflight_q) begin
                mon_dreg_q <= w_ram_q;
            end
            if (take_action_ocimem_a) begin
                mon_areg_q <= jdo[c_JDO_ADDR_LSB +: ADDR_W];
            end else if (rd_inflight_q | (w_jtag_grant & w_req_wr)) begin
                mon_areg_q <= w_addr_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            waitrequest_q <= 1'b1;
            readdata_q    <= '0;
            rd_hold_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_cpu_grant) begin
                        if (read) begin
                            state_q <= ST_RD1;
                        end else begin
                            state_q       <= ST_DONE;
                            waitrequest_q <= 1'b0;
                        end
                    end
                end
                // RAM output is sampled here because a JTAG access may reuse the port next cycle.
                ST_RD1: begin
                    rd_hold_q <= w_ram_q;
                    state_q   <= ST_RD2;
                end
                ST_RD2: begin
                    readdata_q    <= rd_hold_q;
                    state_q       <= ST_DONE;
                    waitrequest_q <= 1'b0;
                end
                ST_DONE: begin
                    state_q       <= ST_IDLE;
                    waitrequest_q <= 1'b1;
                end
                default: begin
                    state_q       <= ST_IDLE;
                    waitrequest_q <= 1'b1;
                end
            endcase
        end
    end

    qsys_sdram_cpu_ociram_sp_ram #(
        .RAM_DEPTH (RAM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .addr_i  (w_ram_addr),
        .we_i    (w_ram_we),
        .re_i    (w_ram_re),
        .be_i    (w_ram_be),
        .wdata_i (w_ram_wdata),
        .q_o     (w_ram_q)
    );

    assign readdata    = readdata_q;
    assign waitrequest = waitrequest_q;
    assign MonDReg     = mon_dreg_q;
    assign MonAReg     = mon_areg_q;

endmodule

`default_nettype wire

// File: tb/tb_qsys_sdram_cpu_ocimem.sv
// ============================================================================
// Module   : tb_qsys_sdram_cpu_ocimem
// Brief    : Directed self-checking bench with a transaction-level memory model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_qsys_sdram_cpu_ocimem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [7:0]  address;
    logic        chipselect, read, write, debugaccess;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;
    bit          cpu_active = 1'b0;
    logic [31:0] mdl_mem [256];
    logic [31:0] exp_dreg;
    logic [7:0]  exp_areg;
    int          lat;

    always #5 clk = ~clk;

    qsys_sdram_cpu_ocimem dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .address                 (address),
        .chipselect              (chipselect),
        .read                    (read),
        .write                   (write),
        .byteenable              (byteenable),
        .writedata               (writedata),
        .debugaccess             (debugaccess),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mon_areg", {24'd0, MonAReg}, {24'd0, exp_areg});
            check("mon_dreg", MonDReg, exp_dreg);
            if (!cpu_active) check("idle_waitrequest", {31'd0, waitrequest}, 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jtag_a(input logic [7:0] a, input logic rd);
        jdo = '0;
        jdo[33:26] = a;
        jdo[34] = rd;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        exp_areg = a;
        if (rd) begin
            tick();
            exp_dreg = mdl_mem[a];
            exp_areg = a + 8'd1;
        end
    endtask

    task automatic jtag_na();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        tick();
        exp_dreg = mdl_mem[exp_areg];
        exp_areg = exp_areg + 8'd1;
    endtask

    task automatic jtag_b(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        mdl_mem[exp_areg] = d;
        exp_dreg = d;
        exp_areg = exp_areg + 8'd1;
    endtask

    // co_jtag pulses a JTAG sequential read in the same cycle the CPU request appears.
    task automatic cpu_xfer(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [3:0] be, input logic [31:0] wd, input logic dbg,
                            input logic co_jtag, output int lat_o);
        logic [31:0] exp_rd;
        logic [31:0] word;
        logic [7:0]  ja;
        int          exp_lat;
        bit          done;
        exp_rd  = mdl_mem[a];
        exp_lat = (rd ? 3 : 1) + (co_jtag ? 1 : 0);
        ja      = exp_areg;
        address = a; chipselect = 1'b1; read = rd; write = wr;
        byteenable = be; writedata = wd; debugaccess = dbg;
        cpu_active = 1'b1;
        if (co_jtag) take_no_action_ocimem_a = 1'b1;
        done  = 1'b0;
        lat_o = -1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!waitrequest) begin
                done  = 1'b1;
                lat_o = k;
                if (rd) check("cpu_readdata", readdata, exp_rd);
            end
            @(posedge clk);
            #1;
            take_no_action_ocimem_a = 1'b0;
            if (co_jtag && k == 1) begin
                exp_dreg = mdl_mem[ja];
                exp_areg = ja + 8'd1;
            end
        end
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        cpu_active = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL cpu_timeout actual=no_completion required=completion");
        end else begin
            check("cpu_latency", lat_o, exp_lat);
        end
        if (!rd && wr && dbg) begin
            word = mdl_mem[a];
            for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
            mdl_mem[a] = word;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        byteenable = '0; writedata = '0; debugaccess = 1'b0;
        exp_dreg = '0; exp_areg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_waitrequest", {31'd0, waitrequest}, 32'd1);
        check("rst_readdata", readdata, 32'd0);
        check("rst_monareg", {24'd0, MonAReg}, 32'd0);
        check("rst_mondreg", MonDReg, 32'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick();

        // JTAG write then addressed read of 0x10
        jtag_a(8'h10, 1'b0);
        jtag_b(32'hDEADBEEF);
        jtag_a(8'h10, 1'b1);
        #2;
        check("req035_dreg", MonDReg, 32'hDEADBEEF);
        check("req035_areg", {24'd0, MonAReg}, 32'h11);
        tick();

        // Auto-increment writes across the wrap point
        jtag_a(8'hFE, 1'b0);
        jtag_b(32'd1);
        jtag_b(32'd2);
        jtag_b(32'd3);
        check("req036_areg", {24'd0, MonAReg}, 32'h01);
        jtag_a(8'hFE, 1'b1);
        check("req036_fe", MonDReg, 32'd1);
        jtag_na();
        check("req036_ff", MonDReg, 32'd2);
        jtag_na();
        check("req036_00", MonDReg, 32'd3);
        check("req036_areg_after", {24'd0, MonAReg}, 32'h01);
        cpu_xfer(1'b1, 1'b0, 8'hFF, 4'h0, 32'd0, 1'b0, 1'b0, lat);
        check("cpu_rd_ff", readdata, 32'd2);
        check("cpu_rd_lat", lat, 3);

        // Byte-enabled CPU writes with and without debugaccess
        cpu_xfer(1'b0, 1'b1, 8'd5, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b0, lat);
        cpu_xfer(1'b0, 1'b1, 8'd5, 4'h3, 32'h12345678, 1'b1, 1'b0, lat);
        check("cpu_wr_lat", lat, 1);
        cpu_xfer(1'b1, 1'b0, 8'd5, 4'h0, 32'd0, 1'b0, 1'b0, lat);
        check("req038_merge", readdata, 32'hFFFF5678);
        cpu_xfer(1'b0, 1'b1, 8'd5, 4'hF, 32'hAAAAAAAA, 1'b0, 1'b0, lat);
        check("nodbg_wr_lat", lat, 1);
        cpu_xfer(1'b1, 1'b0, 8'd5, 4'h0, 32'd0, 1'b0, 1'b0, lat);
        check("req038_nodbg", readdata, 32'hFFFF5678);

        // read and write together behave as a read and leave RAM alone
        cpu_xfer(1'b1, 1'b1, 8'd5, 4'hF, 32'h0, 1'b1, 1'b0, lat);
        check("rdwr_lat", lat, 3);
        cpu_xfer(1'b1, 1'b0, 8'd5, 4'h0, 32'd0, 1'b0, 1'b0, lat);
        check("rdwr_unchanged", readdata, 32'hFFFF5678);

        // Contention: JTAG read wins, CPU completes one cycle later
        jtag_a(8'h10, 1'b0);
        cpu_xfer(1'b1, 1'b0, 8'hFE, 4'h0, 32'd0, 1'b0, 1'b1, lat);
        check("req037_lat", lat, 4);
        check("req037_rdata", readdata, 32'd1);
        check("req037_dreg", MonDReg, 32'hDEADBEEF);
        check("req037_areg", {24'd0, MonAReg}, 32'h11);

        // Reset while the CPU read sits in RD2
        address = 8'hFE; chipselect = 1'b1; read = 1'b1; cpu_active = 1'b1;
        tick();
        tick();
        #2;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("req039_wait", {31'd0, waitrequest}, 32'd1);
        check("req039_areg", {24'd0, MonAReg}, 32'd0);
        check("req039_dreg", MonDReg, 32'd0);
        check("req039_rdata", readdata, 32'd0);
        exp_areg = '0; exp_dreg = '0;
        chipselect = 1'b0; read = 1'b0; cpu_active = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick();
        cpu_xfer(1'b1, 1'b0, 8'h10, 4'h0, 32'd0, 1'b0, 1'b0, lat);
        check("post_rst_lat", lat, 3);
        check("post_rst_rdata", readdata, 32'hDEADBEEF);
        jtag_na();
        check("post_rst_jtag", MonDReg, 32'd3);
        check("post_rst_areg", {24'd0, MonAReg}, 32'h01);
        tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/qsys_sdram_cpu_ocimem.md
QSYS_SDRAM_CPU_OCIMEM -- requirements
Module: qsys_sdram_cpu_ocimem

Interface
REQ-001 Parameter RAM_DEPTH, default 256, on-chip debug RAM depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 8, word-address width; RAM_DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 jdo  in  38  JTAG data from the debug-module sysclk stage, stable while any take_* strobe is high.
REQ-006 take_action_ocimem_a  in  1  one-cycle strobe: load address and optionally start a read.
REQ-007 take_no_action_ocimem_a  in  1  one-cycle strobe: read the next sequential word.
REQ-008 take_action_ocimem_b  in  1  one-cycle strobe: write a word, then auto-increment.
REQ-009 address  in  ADDR_W  CPU Avalon word address.
REQ-010 chipselect, read, write  in  1 each  CPU Avalon controls.
REQ-011 byteenable  in  4  CPU write byte lanes.
REQ-012 writedata  in  32  CPU write data.
REQ-013 debugaccess  in  1  CPU write-enable qualifier; CPU writes SHALL be ignored when 0.
REQ-014 readdata  out  32  CPU read data, valid only in the cycle waitrequest is 0 after a read.
REQ-015 waitrequest  out  1  Avalon stall; 1 at all times except the single completion cycle.
REQ-016 MonDReg  out  32  JTAG-side data register returned to the debug-module tck stage.
REQ-017 MonAReg  out  ADDR_W  current JTAG word address.

Function
REQ-018 take_action_ocimem_a SHALL load MonAReg <= jdo[33:26]; if jdo[34]=1, it SHALL set jtag_rd pending.
REQ-019 take_no_action_ocimem_a SHALL set jtag_rd pending at the current MonAReg.
REQ-020 take_action_ocimem_b SHALL load MonDReg <= jdo[34:3] and set jtag_wr pending (all 4 bytes).
REQ-021 A JTAG read SHALL issue to RAM in the cycle it is granted; MonDReg SHALL update 2 cycles after grant; MonAReg SHALL then increment.
REQ-022 A JTAG write SHALL complete in the grant cycle; MonAReg SHALL increment the following cycle.
REQ-023 MonAReg increment SHALL wrap RAM_DEPTH-1 -> 0.
REQ-024 A new JTAG strobe arriving while a JTAG access is pending but not granted SHALL replace it; a granted access SHALL always complete.
REQ-025 Arbitration: a pending JTAG access SHALL have priority over a CPU access in the same cycle; the CPU keeps waitrequest=1 until granted.
REQ-026 CPU FSM states IDLE, RD1, RD2, DONE: IDLE->RD1 on chipselect&read when granted; RD1->RD2; RD2->DONE with readdata captured; IDLE->DONE on chipselect&write when granted; DONE->IDLE unconditionally; waitrequest=0 only in DONE.
REQ-027 CPU read latency SHALL be 3 cycles from grant to waitrequest=0; CPU write latency SHALL be 1 cycle.
REQ-028 A CPU write with debugaccess=0 SHALL complete the handshake normally without modifying RAM.
REQ-029 read and write both asserted SHALL be treated as a read.
REQ-030 The RAM SHALL be single-ported; at most one access (JTAG or CPU) per cycle.

Reset
REQ-031 On reset_n=0: MonDReg=0, MonAReg=0, readdata=0, waitrequest=1, FSM=IDLE, all pending flags cleared.
REQ-032 Reset asserted mid-access SHALL abort it; RAM contents are not reset and a partially issued write is undefined.

Structure
REQ-033 Shared package SHALL hold RAM_DEPTH/ADDR_W defaults, jdo field positions (address 33:26, read-flag 34, data 34:3) and the CPU FSM state enum.
REQ-034 The RAM SHALL be a sub-module qsys_sdram_cpu_ociram_sp_ram (single-port, byte-enabled, 1-cycle registered read).

Verification
REQ-035 take_action_ocimem_a, jdo[33:26]=0x10, jdo[34]=1 with RAM[0x10]=0xDEADBEEF -> MonDReg=0xDEADBEEF 2 cycles after grant, MonAReg=0x11.
REQ-036 Three take_action_ocimem_b writes of 1,2,3 starting at MonAReg=0xFE -> RAM[0xFE]=1, RAM[0xFF]=2, RAM[0x00]=3, MonAReg=0x01.
REQ-037 CPU read and JTAG read strobed in the same cycle -> JTAG granted first; CPU waitrequest=0 one cycle later than when uncontended.
REQ-038 CPU write 0x12345678, byteenable=0x3, debugaccess=1 to word 5 holding 0xFFFFFFFF -> reads back 0xFFFF5678; repeat with debugaccess=0 -> unchanged, handshake still completes.
REQ-039 reset_n low while FSM is in RD2 -> waitrequest=1, MonAReg=0, FSM=IDLE; next CPU read completes normally.
